adc_spi_sequencer: RTL and testbench
====================================

ADC_SPI_SEQUENCER -- requirements
Module: adc_spi_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: channels scanned, legal 1..8.
REQ-002 SHALL have parameter DATA_W, default 12: SCK pulses per frame and result width, legal 8..16.
REQ-003 SHALL have parameter CLK_DIV, default 25: clk cycles per SCK half-period, legal 2..255.
REQ-004 SHALL have parameter CONV_CYCLES, default 80: clk cycles adc_convst is held high per frame, legal 2..1023.
REQ-005 SHALL have port clk input 1: single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-007 SHALL have port enable input 1: level request to scan continuously.
REQ-008 SHALL have port ready output 1: high only in IDLE.
REQ-009 SHALL have port adc_convst output 1: conversion start to ADC.
REQ-010 SHALL have port adc_sck output 1: SPI clock, idle low.
REQ-011 SHALL have port adc_sdi output 1: config word to ADC.
REQ-012 SHALL have port adc_sdo input 1: result data from ADC.
REQ-013 SHALL have port sample_data output DATA_W: last result.
REQ-014 SHALL have port sample_ch output 3: channel of sample_data.
REQ-015 SHALL have port sample_valid output 1: one-cycle pulse, new result.
REQ-016 SHALL have port scan_done output 1: one-cycle pulse with valid of channel NUM_CH-1.

Function
REQ-017 SHALL implement states IDLE, CONV, XFER, GAP; IDLE->CONV when enable=1; CONV->XFER after CONV_CYCLES; XFER->GAP after DATA_W SCK periods; GAP (2*CLK_DIV cycles, all outputs low) ->CONV if enable=1 else IDLE.
REQ-018 SHALL drive adc_convst high for all of CONV, low elsewhere.
REQ-019 SHALL produce in XFER exactly DATA_W SCK pulses, period 2*CLK_DIV, low half first.
REQ-020 SHALL present adc_sdi MSB first, changing only while SCK low, config word {1, ch[0], ch[2], ch[1], 1, 0} then zeros; adc_sdi=0 outside XFER.
REQ-021 SHALL sample adc_sdo on each SCK rising edge, MSB first, into a DATA_W shift register.
REQ-022 SHALL account for ADC pipelining: the word sent in frame N selects the channel converted at frame N+1; the first frame after leaving IDLE is a priming frame with no sample_valid.
REQ-023 SHALL assert sample_valid for one clk in the cycle after XFER->GAP, updating sample_data and sample_ch (channel selected in the previous frame) in the same cycle; both hold until next valid.
REQ-024 SHALL step channel 0,1,..,NUM_CH-1 and wrap to 0; NUM_CH=1 sends channel 0 every frame.
REQ-025 SHALL sample enable only in IDLE and at GAP exit; deassertion mid-frame completes the current frame including its sample_valid, then enters IDLE and restarts at channel 0 with a new priming frame.

Reset
REQ-026 SHALL, on reset high at any time including mid-frame, immediately force IDLE, channel 0, ready=1, and adc_convst, adc_sck, adc_sdi, sample_data, sample_ch, sample_valid, scan_done all 0.
REQ-027 SHALL hold the reset state while reset is high and leave IDLE no earlier than the first clk edge after reset falls.

Configuration
REQ-028 SHALL, when macro ADC_SEQ_DIFF_MODE_EN is defined, add input diff_mode (1 bit, sampled at IDLE exit) which, when 1, sends S/D bit 0 and limits the scan to min(NUM_CH,4) pairs with sample_ch in 0..3; without the macro there is no such port and S/D is always 1.

Verification
REQ-029 SHALL cover defaults, enable held high, ADC model returning 0xA00+ch: first valid after priming frame carries ch0=0xA00, then 0xA01..0xA03, scan_done with ch3, wrap to ch0.
REQ-030 SHALL cover frame timing: defaults -> adc_convst high 80 cycles, exactly 12 SCK pulses of 50 cycles, frame length 80+600+50 cycles.
REQ-031 SHALL cover SDI words: defaults -> frames send 100010, 110010, 100110, 110110 then repeat.
REQ-032 SHALL cover enable dropped during ch2 XFER -> frame completes, one sample_valid, ready rises after GAP, re-enable restarts priming at ch0.
REQ-033 SHALL cover reset asserted mid-XFER -> same-cycle return of all outputs to REQ-026 values, no further SCK edges.
REQ-034 SHALL cover NUM_CH=1, DATA_W=8, CLK_DIV=2 -> 8 SCK pulses of 4 cycles, every valid reports ch0, scan_done with every valid.

Source files
------------

// File: rtl/adc_spi_sequencer_if.sv
// adc_spi_sequencer_if: control, SPI and result bundle for adc_spi_sequencer; ADC_SEQ_DIFF_MODE_EN adds diff_mode
interface adc_spi_sequencer_if #(
  parameter int DATA_W = 12
);
  logic enable;
  logic ready;
  logic adc_convst;
  logic adc_sck;
  logic adc_sdi;
  logic adc_sdo;
  logic [DATA_W-1:0] sample_data;
  logic [2:0] sample_ch;
  logic sample_valid;
  logic scan_done;
`ifdef ADC_SEQ_DIFF_MODE_EN
  logic diff_mode;
  modport master (
    input enable, diff_mode, adc_sdo,
    output ready, adc_convst, adc_sck, adc_sdi, sample_data, sample_ch, sample_valid, scan_done
  );
  modport slave (
    output enable, diff_mode, adc_sdo,
    input ready, adc_convst, adc_sck, adc_sdi, sample_data, sample_ch, sample_valid, scan_done
  );
`else
  modport master (
    input enable, adc_sdo,
    output ready, adc_convst, adc_sck, adc_sdi, sample_data, sample_ch, sample_valid, scan_done
  );
  modport slave (
    output enable, adc_sdo,
    input ready, adc_convst, adc_sck, adc_sdi, sample_data, sample_ch, sample_valid, scan_done
  );
`endif
endinterface

// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: round-robin SPI ADC scanner with pipelined channel select; ADC_SEQ_DIFF_MODE_EN adds differential pair scanning
module adc_spi_sequencer #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12,
  parameter int CLK_DIV = 25,
  parameter int CONV_CYCLES = 80
) (
  input logic clk,
  input logic reset,
  adc_spi_sequencer_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] GAP = 2'd3;
  localparam int PAIRS = NUM_CH < 4 ? NUM_CH : 4;
  localparam logic [9:0] CONV_M = 10'(CONV_CYCLES - 1);
  localparam logic [9:0] DIV_M = 10'(CLK_DIV - 1);
  localparam logic [9:0] GAP_M = 10'(2 * CLK_DIV - 1);
  localparam logic [4:0] BIT_M = 5'(DATA_W - 1);
  logic [1:0] state;
  logic [9:0] cnt;
  logic [4:0] bc;
  logic sck;
  logic sdi;
  logic primed;
  logic valid;
  logic done;
  logic sd;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] tx;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] data;
  logic [2:0] ch_tx;
  logic [2:0] ch_prev;
  logic [2:0] ch_out;
  logic [2:0] last;
  // config word: S/D, O/S(ch0), S1(ch2), S0(ch1), UNI, SLP, then zero padding
  assign word = {sd, ch_tx[0], ch_tx[2], ch_tx[1], 2'b10, {(DATA_W - 6){1'b0}}};
`ifdef ADC_SEQ_DIFF_MODE_EN
  logic diff;
  assign sd = ~diff;
  assign last = diff ? 3'(PAIRS - 1) : 3'(NUM_CH - 1);
  // diff_mode is captured once per scan, when leaving IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) diff <= 1'b0;
    else if (state == IDLE && bus.enable) diff <= bus.diff_mode;
  end
`else
  assign sd = 1'b1;
  assign last = 3'(NUM_CH - 1);
`endif
  assign bus.ready = state == IDLE;
  assign bus.adc_convst = state == CONV;
  assign bus.adc_sck = sck;
  assign bus.adc_sdi = sdi;
  assign bus.sample_data = data;
  assign bus.sample_ch = ch_out;
  assign bus.sample_valid = valid;
  assign bus.scan_done = done;
  // frame sequencer: conversion, SCK/SDI shifting, SDO capture and result publishing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bc <= '0;
      sck <= 1'b0;
      sdi <= 1'b0;
      primed <= 1'b0;
      valid <= 1'b0;
      done <= 1'b0;
      rx <= '0;
      tx <= '0;
      data <= '0;
      ch_tx <= '0;
      ch_prev <= '0;
      ch_out <= '0;
    end else begin
      valid <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (bus.enable) state <= CONV;
        CONV: begin
          if (cnt == CONV_M) begin
            state <= XFER;
            cnt <= '0;
            bc <= '0;
            sdi <= word[DATA_W-1];
            tx <= {word[DATA_W-2:0], 1'b0};
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        XFER: begin
          if (cnt != DIV_M) begin
            cnt <= cnt + 10'd1;
          end else begin
            cnt <= '0;
            sck <= ~sck;
            if (!sck) begin
              rx <= {rx[DATA_W-2:0], bus.adc_sdo};
            end else if (bc == BIT_M) begin
              state <= GAP;
              sdi <= 1'b0;
              valid <= primed;
              done <= primed && ch_prev == last;
              if (primed) data <= rx;
              if (primed) ch_out <= ch_prev;
              ch_prev <= ch_tx;
              ch_tx <= ch_tx == last ? 3'd0 : ch_tx + 3'd1;
              primed <= 1'b1;
            end else begin
              bc <= bc + 5'd1;
              sdi <= tx[DATA_W-1];
              tx <= {tx[DATA_W-2:0], 1'b0};
            end
          end
        end
        GAP: begin
          if (cnt == GAP_M) begin
            cnt <= '0;
            state <= bus.enable ? CONV : IDLE;
            if (!bus.enable) ch_tx <= '0;
            if (!bus.enable) primed <= 1'b0;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_spi_sequencer.sv
// tb_adc_spi_sequencer: scoreboard bench for adc_spi_sequencer with behavioural pipelined ADC models
module tb_adc_spi_sequencer;
  typedef struct packed {
    logic [2:0] ch;
    logic [11:0] d;
    logic done;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t a_q[$];
  logic [11:0] a_sdi_q[$];
  logic [7:0] b_q[$];
  logic [11:0] sdi_words [4] = '{12'h880, 12'hC80, 12'h980, 12'hD80};
  adc_spi_sequencer_if #(.DATA_W(12)) a();
  adc_spi_sequencer_if #(.DATA_W(8)) b();
  adc_spi_sequencer dut_a (.clk(clk), .reset(reset), .bus(a.master));
  adc_spi_sequencer #(.NUM_CH(1), .DATA_W(8), .CLK_DIV(2), .CONV_CYCLES(10)) dut_b (.clk(clk), .reset(reset), .bus(b.master));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ADC model A: channel decoded from the previous frame's config, result 0xA00+ch
  logic [11:0] a_out = '0;
  logic [11:0] a_word = '0;
  logic [5:0] a_cfg = '0;
  int a_pulses = 0;
  assign a.adc_sdo = a_out[11];
  always @(posedge a.adc_convst or negedge a.adc_sck)
    if (a.adc_convst) a_out = 12'hA00 + {9'd0, a_cfg[3], a_cfg[2], a_cfg[4]};
    else a_out = {a_out[10:0], 1'b0};
  always @(posedge a.adc_sck) begin
    if (a_pulses < 6) a_cfg = {a_cfg[4:0], a.adc_sdi};
    a_word = {a_word[10:0], a.adc_sdi};
    if (a_pulses == 11 && a_sdi_q.size() > 0) chk("a_sdi_word", 32'(a_word), 32'(a_sdi_q.pop_front()));
  end

  // ADC model B: 8-bit result 0x50+ch
  logic [7:0] b_out = '0;
  logic [5:0] b_cfg = '0;
  int b_pulses = 0;
  assign b.adc_sdo = b_out[7];
  always @(posedge b.adc_convst or negedge b.adc_sck)
    if (b.adc_convst) b_out = 8'h50 + {5'd0, b_cfg[3], b_cfg[2], b_cfg[4]};
    else b_out = {b_out[6:0], 1'b0};
  always @(posedge b.adc_sck)
    if (b_pulses < 6) b_cfg = {b_cfg[4:0], b.adc_sdi};

  // monitor A: timing measurements and result scoreboard
  int a_conv_len = 0, a_first = 0, a_per = 0, a_hi = 0, a_frame_pulses = 0, a_frame_len = 0;
  int a_rise = 0, a_cfall = 0, a_srise = 0, a_vcyc = 0, a_rdy_cyc = 0, a_sck_total = 0, a_extra = 0;
  logic a_pc = 1'b0, a_ps = 1'b0, a_pr = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (a.adc_convst && !a_pc) begin
      a_frame_len = cyc - a_rise;
      a_rise = cyc;
      a_frame_pulses = a_pulses;
      a_pulses = 0;
    end
    if (!a.adc_convst && a_pc) begin
      a_conv_len = cyc - a_rise;
      a_cfall = cyc;
    end
    if (a.adc_sck && !a_ps) begin
      if (a_pulses == 0) a_first = cyc - a_cfall;
      else a_per = cyc - a_srise;
      a_srise = cyc;
      a_pulses++;
      a_sck_total++;
    end
    if (!a.adc_sck && a_ps) a_hi = cyc - a_srise;
    if (a.ready && !a_pr) a_rdy_cyc = cyc;
    if (a.scan_done && !a.sample_valid) a_extra++;
    if (a.sample_valid) begin
      a_vcyc = cyc;
      if (a_q.size() > 0) begin
        e = a_q.pop_front();
        chk("a_data", 32'(a.sample_data), 32'(e.d));
        chk("a_ch", 32'(a.sample_ch), 32'(e.ch));
        chk("a_scan_done", 32'(a.scan_done), 32'(e.done));
      end else a_extra++;
    end
    a_pc = a.adc_convst;
    a_ps = a.adc_sck;
    a_pr = a.ready;
  end

  // monitor B: pulse count, SCK period and result scoreboard
  int b_per = 0, b_srise = 0, b_frame_pulses = 0, b_extra = 0;
  logic b_pc = 1'b0, b_ps = 1'b0;
  always @(negedge clk) begin
    if (b.adc_convst && !b_pc) begin
      b_frame_pulses = b_pulses;
      b_pulses = 0;
    end
    if (b.adc_sck && !b_ps) begin
      if (b_pulses > 0) b_per = cyc - b_srise;
      b_srise = cyc;
      b_pulses++;
    end
    if (b.scan_done && !b.sample_valid) b_extra++;
    if (b.sample_valid) begin
      if (b_q.size() > 0) begin
        chk("b_data", 32'(b.sample_data), 32'(b_q.pop_front()));
        chk("b_ch", 32'(b.sample_ch), 0);
        chk("b_scan_done", 32'(b.scan_done), 1);
      end else b_extra++;
    end
    b_pc = b.adc_convst;
    b_ps = b.adc_sck;
  end

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    a.enable = 1'b0;
    b.enable = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(a.ready), 1);
    chk("rst_convst", 32'(a.adc_convst), 0);
    chk("rst_sck", 32'(a.adc_sck), 0);
    chk("rst_sdi", 32'(a.adc_sdi), 0);
    chk("rst_data", 32'(a.sample_data), 0);
    chk("rst_valid", 32'(a.sample_valid), 0);
    chk("rst_b_ready", 32'(b.ready), 1);
    reset = 1'b0;
    repeat (5) tick();
    chk("idle_no_enable", 32'(a.ready), 1);
    for (int i = 0; i < 6; i++) a_q.push_back('{ch: 3'(i % 4), d: 12'hA00 + 12'(i % 4), done: (i % 4) == 3});
    for (int i = 0; i < 7; i++) a_sdi_q.push_back(sdi_words[i % 4]);
    a.enable = 1'b1;
    for (int i = 0; i < 10000 && a_q.size() > 1; i++) tick();
    chk("scan_valids", 32'(a_q.size()), 1);
    chk("conv_len", a_conv_len, 80);
    chk("sck_low_first", a_first, 25);
    chk("sck_period", a_per, 50);
    chk("sck_high", a_hi, 25);
    chk("frame_pulses", a_frame_pulses, 12);
    chk("frame_len", a_frame_len, 730);
    for (int i = 0; i < 2000 && !a.adc_sck; i++) tick();
    chk("ch2_xfer_seen", 32'(a.adc_sck), 1);
    a.enable = 1'b0;
    for (int i = 0; i < 2000 && !a.ready; i++) tick();
    chk("drop_idle", 32'(a.ready), 1);
    chk("drop_valid_done", 32'(a_q.size()), 0);
    chk("drop_ready_delay", a_rdy_cyc - a_vcyc, 50);
    chk("drop_sdi_done", 32'(a_sdi_q.size()), 0);
    repeat (200) tick();
    chk("drop_no_extra", a_extra, 0);
    chk("drop_stay_idle", 32'(a.ready), 1);
    a_q.push_back('{ch: 3'd0, d: 12'hA00, done: 1'b0});
    a_sdi_q.push_back(12'h880);
    a_sdi_q.push_back(12'hC80);
    a.enable = 1'b1;
    for (int i = 0; i < 3000 && a_q.size() > 0; i++) tick();
    chk("restart_valid", 32'(a_q.size()), 0);
    chk("restart_sdi", 32'(a_sdi_q.size()), 0);
    for (int i = 0; i < 2000 && !a.adc_sck; i++) tick();
    chk("xfer3_seen", 32'(a.adc_sck), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(a.ready), 1);
    chk("mid_rst_convst", 32'(a.adc_convst), 0);
    chk("mid_rst_sck", 32'(a.adc_sck), 0);
    chk("mid_rst_sdi", 32'(a.adc_sdi), 0);
    chk("mid_rst_data", 32'(a.sample_data), 0);
    chk("mid_rst_ch", 32'(a.sample_ch), 0);
    chk("mid_rst_valid", 32'(a.sample_valid), 0);
    chk("mid_rst_done", 32'(a.scan_done), 0);
    s0 = a_sck_total;
    repeat (20) tick();
    chk("rst_hold_ready", 32'(a.ready), 1);
    chk("rst_hold_convst", 32'(a.adc_convst), 0);
    chk("rst_no_sck", a_sck_total - s0, 0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 32'(a.ready), 1);
    tick();
    chk("rst_exit_conv", 32'(a.adc_convst), 1);
    a.enable = 1'b0;
    for (int i = 0; i < 2000 && !a.ready; i++) tick();
    chk("prime_idle", 32'(a.ready), 1);
    chk("prime_no_valid", a_extra, 0);
    for (int i = 0; i < 4; i++) b_q.push_back(8'h50);
    b.enable = 1'b1;
    for (int i = 0; i < 2000 && b_q.size() > 0; i++) tick();
    b.enable = 1'b0;
    chk("b_valids", 32'(b_q.size()), 0);
    chk("b_pulses", b_frame_pulses, 8);
    chk("b_period", b_per, 4);
    for (int i = 0; i < 500 && !b.ready; i++) tick();
    chk("b_idle", 32'(b.ready), 1);
    chk("b_no_extra", b_extra, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
